// File: rtl/blink_arbiter.sv
// blink_arbiter -- round-robin arbiter for three channels sharing one LED.
//
// A granted channel blinks the shared LED N times (N latched from its nibble
// of blinks), each blink one lit phase plus one dark phase of TICK_MAX+1
// clocks, followed by GAP_TICKS dark phases. The service then ends with a
// one-clock done pulse and the arbiter returns to IDLE for at least one cycle.
//
// Ports:
//   clock   in   1   sole clock, rising edge
//   reset   in   1   asynchronous active-high reset
//   req     in   3   per-channel request level, sampled only in IDLE
//   blinks  in  12   per-channel blink count, [4i+3:4i] = channel i
//   grant   out  3   one-hot channel in service, 000 when idle
//   busy    out  1   high while a channel is granted
//   done    out  3   one-clock completion pulse for the served channel
//   led_n   out  1   shared LED drive, active-low

module blink_arbiter #(
  parameter logic [24:0] TICK_MAX  = 25'd23_999_999,
  parameter int          GAP_TICKS = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [11:0] blinks,
  output logic [2:0]  grant,
  output logic        busy,
  output logic [2:0]  done,
  output logic        led_n
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } state_t;

  // Last gap phase index; with GAP_TICKS == 0 the GAP state is skipped.
  localparam logic [15:0] GAP_LAST = 16'(GAP_TICKS - 1);
  localparam logic        NO_GAP   = (GAP_TICKS == 0) ? 1'b1 : 1'b0;

  state_t      state_r;
  logic [24:0] phase_r;
  logic [3:0]  remain_r;
  logic [1:0]  ptr_r;      // last-served channel
  logic [1:0]  cur_r;      // channel in service
  logic        zero_r;     // current service latched a count of zero
  logic [15:0] gap_r;      // gap phases already completed

  logic        tick_s;
  logic        win_vld_s;
  logic [1:0]  win_s;
  logic [3:0]  win_blinks_s;
  logic [2:0]  win_onehot_s;
  logic [2:0]  cur_onehot_s;

  // Round-robin pick: search starts at the channel after 'last'.
  // Result is {valid, index}.
  function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [2:0] res;
    res = 3'b000;
    case (last)
      2'd0: begin
        if (r[1])      res = 3'b101;
        else if (r[2]) res = 3'b110;
        else if (r[0]) res = 3'b100;
        else           res = 3'b000;
      end
      2'd1: begin
        if (r[2])      res = 3'b110;
        else if (r[0]) res = 3'b100;
        else if (r[1]) res = 3'b101;
        else           res = 3'b000;
      end
      default: begin
        if (r[0])      res = 3'b100;
        else if (r[1]) res = 3'b101;
        else if (r[2]) res = 3'b110;
        else           res = 3'b000;
      end
    endcase
    return res;
  endfunction

  function automatic logic [2:0] to_onehot(input logic [1:0] idx);
    logic [2:0] oh;
    case (idx)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  assign tick_s = (phase_r == TICK_MAX) ? 1'b1 : 1'b0;

  // Arbitration winner and its blink count, evaluated every cycle but only used in IDLE.
  always_comb begin
    {win_vld_s, win_s} = rr_pick(req, ptr_r);
    win_onehot_s       = to_onehot(win_s);
    cur_onehot_s       = to_onehot(cur_r);
    case (win_s)
      2'd0:    win_blinks_s = blinks[3:0];
      2'd1:    win_blinks_s = blinks[7:4];
      2'd2:    win_blinks_s = blinks[11:8];
      default: win_blinks_s = 4'd0;
    endcase
  end

  // Service FSM with phase counter and all registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      grant    <= 3'b000;
      busy     <= 1'b0;
      done     <= 3'b000;
      led_n    <= 1'b1;
      phase_r  <= 25'd0;
      remain_r <= 4'd0;
      ptr_r    <= 2'd2;
      cur_r    <= 2'd0;
      zero_r   <= 1'b0;
      gap_r    <= 16'd0;
    end else begin
      done <= 3'b000;
      case (state_r)
        IDLE: begin
          phase_r <= 25'd0;
          gap_r   <= 16'd0;
          led_n   <= 1'b1;
          if (win_vld_s) begin
            grant    <= win_onehot_s;
            busy     <= 1'b1;
            cur_r    <= win_s;
            remain_r <= win_blinks_s;
            if (win_blinks_s == 4'd0) begin
              // Zero count: one dark grant cycle, then straight to done.
              zero_r  <= 1'b1;
              state_r <= GAP;
            end else begin
              zero_r  <= 1'b0;
              state_r <= ON;
              led_n   <= 1'b0;
            end
          end else begin
            grant <= 3'b000;
            busy  <= 1'b0;
          end
        end
        ON: begin
          phase_r <= tick_s ? 25'd0 : phase_r + 25'd1;
          if (tick_s) begin
            state_r  <= OFF;
            led_n    <= 1'b1;
            remain_r <= remain_r - 4'd1;
          end
        end
        OFF: begin
          phase_r <= tick_s ? 25'd0 : phase_r + 25'd1;
          if (tick_s) begin
            if (remain_r != 4'd0) begin
              state_r <= ON;
              led_n   <= 1'b0;
            end else if (NO_GAP) begin
              state_r <= IDLE;
              grant   <= 3'b000;
              busy    <= 1'b0;
              done    <= cur_onehot_s;
              ptr_r   <= cur_r;
              phase_r <= 25'd0;
            end else begin
              state_r <= GAP;
            end
          end
        end
        GAP: begin
          phase_r <= tick_s ? 25'd0 : phase_r + 25'd1;
          if (zero_r || (tick_s && (gap_r == GAP_LAST))) begin
            state_r <= IDLE;
            grant   <= 3'b000;
            busy    <= 1'b0;
            done    <= cur_onehot_s;
            ptr_r   <= cur_r;
            phase_r <= 25'd0;
            gap_r   <= 16'd0;
            zero_r  <= 1'b0;
          end else if (tick_s) begin
            gap_r <= gap_r + 16'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          grant   <= 3'b000;
          busy    <= 1'b0;
          led_n   <= 1'b1;
          phase_r <= 25'd0;
        end
      endcase
    end
  end

endmodule
